// File: rtl/hall_commutator.sv
// hall_commutator: Hall-sensor six-step commutation with dead time, speed period measurement, stall and fault detection (optional glitch filter: HALL_COMMUTATOR_GLITCH_FILTER_EN)
module hall_commutator #(
    parameter int DEAD_CYCLES  = 27,
    parameter int STALL_CYCLES = 2700000,
    parameter int PERIOD_W     = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                dir,
    input  logic                hall_u,
    input  logic                hall_v,
    input  logic                hall_w,
    output logic                hin_r,
    output logic                hin_s,
    output logic                hin_t,
    output logic                lin_r,
    output logic                lin_s,
    output logic                lin_t,
    output logic [2:0]          sector,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stall,
    output logic                fault
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DEAD, DRIVE, FAULT} state_t;

    state_t              state, nxt;
    logic [2:0]          s1, s2, code_q, code_d;
    logic [5:0]          fwd, target, pat_q;
    logic [DW-1:0]       dcnt;
    logic [PERIOD_W-1:0] cnt;
    logic                valid, valid_d, chg, armed;

`ifdef HALL_COMMUTATOR_GLITCH_FILTER_EN
    logic [2:0] h1, h2;
    // synchronize pins; accept a code only after three identical synchronized samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            h1 <= '0;
            h2 <= '0;
            code_q <= '0;
        end else begin
            s1 <= {hall_u, hall_v, hall_w};
            s2 <= s1;
            h1 <= s2;
            h2 <= h1;
            if (s2 == h1 && h1 == h2) code_q <= s2;
        end
    end
`else
    // synchronize pins and accept the synchronized code every cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
            code_q <= '0;
        end else begin
            s1 <= {hall_u, hall_v, hall_w};
            s2 <= s1;
            code_q <= s2;
        end
    end
`endif

    // Hall code to sector; 000 and 111 are impossible rotor positions
    always_comb begin
        case (code_q)
            3'b101:  sector = 3'd0;
            3'b100:  sector = 3'd1;
            3'b110:  sector = 3'd2;
            3'b010:  sector = 3'd3;
            3'b011:  sector = 3'd4;
            3'b001:  sector = 3'd5;
            default: sector = 3'd7;
        endcase
    end

    // forward {hin_rst, lin_rst} per sector; reverse swaps high and low sides
    always_comb begin
        case (sector)
            3'd0:    fwd = 6'b100_010;
            3'd1:    fwd = 6'b100_001;
            3'd2:    fwd = 6'b010_001;
            3'd3:    fwd = 6'b010_100;
            3'd4:    fwd = 6'b001_100;
            3'd5:    fwd = 6'b001_010;
            default: fwd = 6'b000_000;
        endcase
        target = dir ? {fwd[2:0], fwd[5:3]} : fwd;
    end

    assign valid = sector != 3'd7;
    assign chg   = valid && valid_d && code_q != code_d;

    // next state: dropping enable wins over everything, an invalid code wins while enabled
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (enable) nxt = valid ? DEAD : FAULT;
            DEAD:    nxt = !valid ? FAULT : (dcnt == DW'(DEAD_CYCLES - 1)) ? DRIVE : DEAD;
            DRIVE:   nxt = !valid ? FAULT : (target != pat_q) ? DEAD : DRIVE;
            default: nxt = FAULT;
        endcase
        if (!enable) nxt = IDLE;
    end

    // state, dead-time counter, and the pattern latched on entry to DRIVE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dcnt  <= '0;
            pat_q <= '0;
        end else begin
            state <= nxt;
            dcnt  <= (state == DEAD) ? dcnt + 1'b1 : '0;
            if (nxt == DRIVE) pat_q <= target;
        end
    end

    assign {hin_r, hin_s, hin_t, lin_r, lin_s, lin_t} = (state == DRIVE) ? pat_q : 6'b0;
    assign fault = state == FAULT;

    // edge-to-edge period measurement; the first interval after reset or stall is unreliable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_d       <= '0;
            valid_d      <= 1'b0;
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stall        <= 1'b0;
            armed        <= 1'b0;
        end else begin
            code_d       <= code_q;
            valid_d      <= valid;
            period_valid <= chg && armed;
            if (chg) begin
                cnt   <= '0;
                stall <= 1'b0;
                armed <= 1'b1;
                if (armed) period <= cnt + 1'b1;
            end else begin
                cnt <= (cnt == '1) ? cnt : cnt + 1'b1;
                if (cnt == PERIOD_W'(STALL_CYCLES)) begin
                    stall <= 1'b1;
                    armed <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/hall_commutator.md
# hall_commutator

Six-step trapezoidal commutation block for the brushless driver: synchronizes the three Hall sensor inputs, decodes the rotor sector, and drives the three-phase bridge gate enables with break-before-make dead time. It is the sensing-side counterpart of the tick timer. Instead of generating periodic overflow pulses, it measures the interval between Hall edges and reports it as a clock-cycle period for speed control. It sits between the Hall pins and the HIN/LIN gate-driver pins.

## Interface
- `DEAD_CYCLES`, 27: gate-off cycles inserted on every drive-pattern change (1 µs at 27 MHz); ≥1
- `STALL_CYCLES`, 2700000: cycles without a Hall change before `stall` asserts (100 ms)
- `PERIOD_W`, 24: width of the period measurement; must hold `STALL_CYCLES`
- `clk`  in  1  system clock, 27 MHz
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  level; 1 = drive the bridge
- `dir`  in  1  0 = forward, 1 = reverse
- `hall_u`, `hall_v`, `hall_w`  in  1 each  raw Hall inputs, asynchronous
- `hin_r`, `hin_s`, `hin_t`  out  1 each  high-side gate enables
- `lin_r`, `lin_s`, `lin_t`  out  1 each  low-side gate enables
- `sector`  out  3  decoded sector 0–5; 7 = invalid
- `period`  out  PERIOD_W  cycles between the last two accepted Hall changes
- `period_valid`  out  1  one-cycle pulse when `period` updates
- `stall`  out  1  no Hall change for `STALL_CYCLES`
- `fault`  out  1  invalid Hall code latched

## Operation
- **Synchronization:** each Hall input passes through a 2-FF synchronizer. The accepted code is `code = {u,v,w}`, held in register `code_q`.
- **Sector decode:**
  - 101→0, 100→1, 110→2, 010→3, 011→4, 001→5.
  - 000 and 111 are invalid and map to 7.
- **Forward drive pattern (high, low) per sector:**
  - 0: (R, S); 1: (R, T); 2: (S, T); 3: (S, R); 4: (T, R); 5: (T, S).
  - Reverse: the high and low phases of each sector are swapped.
  - At most one `hin` and one `lin` is high at any time, and never both on the same phase.
- **FSM states:** IDLE, DEAD, DRIVE, FAULT.
  - **IDLE:** all gates 0. Goes to DEAD when `enable`=1 and the code is valid. Goes to FAULT when `enable`=1 and the code is invalid.
  - **DEAD:** all gates 0 and the dead counter counts. After `DEAD_CYCLES` cycles, goes to DRIVE and applies the target pattern.
    - A new valid sector or `dir` change during DEAD updates the target only. The counter does not restart.
  - **DRIVE:** outputs the target pattern.
    - A sector change or `dir` change goes to DEAD; gates are 0 the next cycle.
    - An invalid code goes to FAULT.
  - **FAULT:** all gates 0 and `fault`=1. Goes to IDLE only when `enable`=0; `fault` clears on that exit.
  - **Any state:** `enable`=0 goes to IDLE with gates 0 the next cycle and no dead interval. An invalid code has priority over `enable` when both change in the same cycle while `enable` stays 1.
- **Period counter:**
  - Free-running; saturates at `2^PERIOD_W−1`.
  - On each accepted change between two valid codes: `period`←counter+1, `period_valid`=1 for one cycle, counter←0.
  - The first change after reset or after a `stall` is measured but `period_valid` is suppressed. `period` holds its old value.
- **Stall:** `stall`=1 when the counter reaches `STALL_CYCLES`. It clears on the next accepted valid change. It is status only and does not affect the gates.

## Timing
- **Reset values:** all gates 0, `sector`=7, `period`=0, `period_valid`=0, `stall`=0, `fault`=0, state IDLE, counters 0.
- **Hall pin to `code_q`/`sector`:** 3 clock edges (2 synchronizer edges + 1 accept edge).
- **`code_q` change to gates 0:** 1 cycle.
- **Gates 0 to new pattern:** exactly `DEAD_CYCLES` cycles.
- **`enable` rise to first drive:** 1 + `DEAD_CYCLES` cycles.
- **`period_valid`:** asserted in the same cycle that `period` updates (1 cycle after the `code_q` change).
- **Reset mid-operation:** gates drop asynchronously.

## Configuration
- `HALL_COMMUTATOR_GLITCH_FILTER_EN` defined: a synchronized code must be identical for 3 consecutive cycles before it loads `code_q`. This adds 2 cycles of latency, and shorter pulses are ignored.
- Undefined: the synchronized code loads `code_q` every cycle.

## Test plan
- **Forward run:** `DEAD_CYCLES`=4, enable=1, dir=0. Hall sequence 101,100,110,010,011,001, each held 50 cycles.
  - Required: patterns (R,S),(R,T),(S,T),(S,R),(T,R),(T,S).
  - Exactly 4 all-zero cycles before each pattern.
  - `period`=50 with `period_valid` from the second change onward.
- **Reverse:** dir=1, sector 0 → `hin_s`=1, `lin_r`=1. Toggling dir while in DRIVE → 4 dead cycles, then the swapped pattern.
- **Invalid code:** Hall 111 in DRIVE → gates 0 the next cycle and `fault`=1. `fault` clears only after enable=0.
- **Stall:** `STALL_CYCLES`=100, Hall held static.
  - `stall`=1 at count 100.
  - On the next change, `stall`=0 and there is no `period_valid`.
  - On the following change, `period_valid`=1.
- **Async reset mid-DRIVE:** assert `rst` between clock edges → gates 0 immediately and all outputs at their reset values.
- **Glitch filter (macro on):** a 2-cycle Hall pulse is ignored, with `sector` unchanged. A 3-cycle hold is accepted, with 5-edge pin-to-sector latency.
